// File: rtl/spi_apb_pkg.sv
// ============================================================================
// spi_apb_pkg: register map, write masks, SR bit indices and mode encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_apb_pkg;

    localparam logic [2:0] ADDR_CR1 = 3'd0;
    localparam logic [2:0] ADDR_CR2 = 3'd1;
    localparam logic [2:0] ADDR_BR  = 3'd2;
    localparam logic [2:0] ADDR_SR  = 3'd3;
    localparam logic [2:0] ADDR_DR  = 3'd5;

    localparam logic [7:0] CR1_RESET = 8'h04;
    localparam logic [7:0] CR2_WMASK = 8'h1B;
    localparam logic [7:0] BR_WMASK  = 8'h77;

    localparam int CR1_SPIE  = 7;
    localparam int CR1_SPE   = 6;
    localparam int CR1_SPTIE = 5;
    localparam int CR1_MSTR  = 4;
    localparam int CR1_CPOL  = 3;
    localparam int CR1_CPHA  = 2;
    localparam int CR1_SSOE  = 1;
    localparam int CR1_LSBFE = 0;

    localparam int CR2_MODFEN  = 4;
    localparam int CR2_SPISWAI = 1;

    localparam int SR_SPIF    = 7;
    localparam int SR_RXOVR   = 6;
    localparam int SR_SPTEF   = 5;
    localparam int SR_MODF    = 4;
    localparam int SR_TXEMPTY = 3;
    localparam int SR_RXFULL  = 2;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_WAIT = 2'b01,
        MODE_STOP = 2'b10,
        MODE_RSVD = 2'b11
    } spi_mode_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_fifo.sv
// ============================================================================
// spi_sync_fifo: count-based synchronous FIFO, pointer/count cleared asynchronously
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push at full is legal alongside it
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/spi_apb_fifo_ctrl.sv
// ============================================================================
// spi_apb_fifo_ctrl: APB register front-end with TX/RX FIFOs and mode FSM for an SPI core.
// Define SPI_IRQ_EN to enable the registered interrupt output and CR1 spie/sptie.
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_apb_fifo_ctrl
    import spi_apb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [2:0]        PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    input  logic              tip_i,
    input  logic              ss_i,
    output logic              mstr_o,
    output logic              cpol_o,
    output logic              cpha_o,
    output logic              lsbfe_o,
    output logic [2:0]        sppr_o,
    output logic [2:0]        spr_o,
    output logic [1:0]        spi_mode_o,
    output logic              irq_o
);

`ifdef SPI_IRQ_EN
    localparam logic [7:0] CR1_WMASK = 8'hFF;
`else
    localparam logic [7:0] CR1_WMASK = 8'h5F;
`endif

    logic [7:0]        cr1_q, cr2_q, br_q;
    logic              modf_q, rxovr_q, sr_rd_q;
    spi_mode_e         mode_q, mode_d;
    logic              access, acc_err, acc_ok;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic              wr_cr1, wr_cr2, wr_br, rd_sr;
    logic [7:0]        sr;
    logic [7:0]        reg_rd;

    assign access  = PSEL & PENABLE;
    assign PREADY  = access;
    assign PSLVERR = access & acc_err;
    assign acc_ok  = access & ~acc_err;

    assign tx_valid_o = ~tx_empty & cr1_q[CR1_SPE] & (mode_q != MODE_STOP);
    assign tx_pop     = tx_valid_o & tx_ready_i;

    always_comb begin
        acc_err = 1'b0;
        case (PADDR)
            ADDR_CR1, ADDR_CR2, ADDR_BR: acc_err = PWRITE & tip_i;
            ADDR_SR:                     acc_err = PWRITE;
            ADDR_DR:                     acc_err = PWRITE ? (tx_full & ~tx_pop) : rx_empty;
            default:                     acc_err = 1'b1;
        endcase
    end

    assign wr_cr1  = acc_ok & PWRITE  & (PADDR == ADDR_CR1);
    assign wr_cr2  = acc_ok & PWRITE  & (PADDR == ADDR_CR2);
    assign wr_br   = acc_ok & PWRITE  & (PADDR == ADDR_BR);
    assign rd_sr   = acc_ok & ~PWRITE & (PADDR == ADDR_SR);
    assign tx_push = acc_ok & PWRITE  & (PADDR == ADDR_DR);
    assign rx_pop  = acc_ok & ~PWRITE & (PADDR == ADDR_DR);

    spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .push_i   (tx_push),
        .wdata_i  (PWDATA),
        .pop_i    (tx_pop),
        .rdata_o  (tx_data_o),
        .full_o   (tx_full),
        .empty_o  (tx_empty)
    );

    spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .PCLK     (PCLK),
        .PRESET_n (PRESET_n),
        .push_i   (rx_valid_i),
        .wdata_i  (rx_data_i),
        .pop_i    (rx_pop),
        .rdata_o  (rx_head),
        .full_o   (rx_full),
        .empty_o  (rx_empty)
    );

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cr1_q <= CR1_RESET;
            cr2_q <= '0;
            br_q  <= '0;
        end else begin
            if (wr_cr1) cr1_q <= PWDATA[7:0] & CR1_WMASK;
            if (wr_cr2) cr2_q <= PWDATA[7:0] & CR2_WMASK;
            if (wr_br)  br_q  <= PWDATA[7:0] & BR_WMASK;
        end
    end

    // Flag clear is a two-step handshake: an SR read arms it, the next CR1 write fires it
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            modf_q  <= 1'b0;
            rxovr_q <= 1'b0;
            sr_rd_q <= 1'b0;
        end else begin
            if (wr_cr1) begin
                sr_rd_q <= 1'b0;
            end else if (rd_sr) begin
                sr_rd_q <= 1'b1;
            end
            if (wr_cr1 && sr_rd_q) begin
                modf_q  <= 1'b0;
                rxovr_q <= 1'b0;
            end else begin
                if (~ss_i & cr1_q[CR1_MSTR] & cr2_q[CR2_MODFEN] & ~cr1_q[CR1_SSOE])
                    modf_q <= 1'b1;
                if (rx_valid_i & rx_full & ~rx_pop)
                    rxovr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) mode_q <= MODE_RUN;
        else           mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_RUN:  if (!cr1_q[CR1_SPE]) mode_d = MODE_WAIT;
            MODE_WAIT: begin
                if (cr1_q[CR1_SPE])           mode_d = MODE_RUN;
                else if (cr2_q[CR2_SPISWAI])  mode_d = MODE_STOP;
            end
            MODE_STOP: if (!cr2_q[CR2_SPISWAI]) mode_d = MODE_WAIT;
            default:   mode_d = MODE_RUN;
        endcase
    end

    always_comb begin
        sr              = '0;
        sr[SR_SPIF]     = ~rx_empty;
        sr[SR_RXOVR]    = rxovr_q;
        sr[SR_SPTEF]    = ~tx_full;
        sr[SR_MODF]     = modf_q;
        sr[SR_TXEMPTY]  = tx_empty;
        sr[SR_RXFULL]   = rx_full;
    end

    always_comb begin
        reg_rd = '0;
        case (PADDR)
            ADDR_CR1: reg_rd = cr1_q;
            ADDR_CR2: reg_rd = cr2_q;
            ADDR_BR:  reg_rd = br_q;
            ADDR_SR:  reg_rd = sr;
            default:  reg_rd = '0;
        endcase
        PRDATA = (PADDR == ADDR_DR) ? rx_head : DATA_W'(reg_rd);
    end

`ifdef SPI_IRQ_EN
    logic irq_q;
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) irq_q <= 1'b0;
        else           irq_q <= (cr1_q[CR1_SPIE] & (~rx_empty | modf_q | rxovr_q))
                              | (cr1_q[CR1_SPTIE] & ~tx_full);
    end
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign mstr_o     = cr1_q[CR1_MSTR];
    assign cpol_o     = cr1_q[CR1_CPOL];
    assign cpha_o     = cr1_q[CR1_CPHA];
    assign lsbfe_o    = cr1_q[CR1_LSBFE];
    assign sppr_o     = br_q[6:4];
    assign spr_o      = br_q[2:0];
    assign spi_mode_o = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_apb_fifo_ctrl.sv
// ============================================================================
// tb_spi_apb_fifo_ctrl: directed self-checking bench for spi_apb_fifo_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_apb_fifo_ctrl;

    logic       PCLK = 1'b0;
    logic       PRESET_n;
    logic       PSEL, PENABLE, PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;
    logic [7:0] tx_data_o;
    logic       tx_valid_o, tx_ready_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i, tip_i, ss_i;
    logic       mstr_o, cpol_o, cpha_o, lsbfe_o;
    logic [2:0] sppr_o, spr_o;
    logic [1:0] spi_mode_o;
    logic       irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rdat;
    logic       perr;

    always #5 PCLK = ~PCLK;

    spi_apb_fifo_ctrl #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
        .tip_i(tip_i), .ss_i(ss_i),
        .mstr_o(mstr_o), .cpol_o(cpol_o), .cpha_o(cpha_o), .lsbfe_o(lsbfe_o),
        .sppr_o(sppr_o), .spr_o(spr_o), .spi_mode_o(spi_mode_o), .irq_o(irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the access edge
    task automatic xfer(input logic wr, input logic [2:0] a, input logic [7:0] d,
                        input logic rdy, output logic [7:0] rd, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; tx_ready_i = rdy;
        @(negedge PCLK);
        rd  = PRDATA;
        err = PSLVERR;
        check("pready", PREADY, 1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; tx_ready_i = 1'b0;
    endtask

    task automatic apb_wr(input logic [2:0] a, input logic [7:0] d, output logic err);
        logic [7:0] dummy;
        xfer(1'b1, a, d, 1'b0, dummy, err);
    endtask

    task automatic apb_rd(input logic [2:0] a, output logic [7:0] d, output logic err);
        xfer(1'b0, a, 8'h00, 1'b0, d, err);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
        end
    endtask

    task automatic tx_pulse();
        tx_ready_i = 1'b1;
        @(posedge PCLK); #1;
        tx_ready_i = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data_i = d; rx_valid_i = 1'b1;
        @(posedge PCLK); #1;
        rx_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_tx [4];
        PRESET_n = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        tx_ready_i = 0; rx_data_i = 0; rx_valid_i = 0; tip_i = 0; ss_i = 1'b1;
        cycles(3);
        check("rst_txvalid", tx_valid_o, 0);
        check("rst_irq", irq_o, 0);
        check("rst_pslverr", PSLVERR, 0);
        check("rst_mode", spi_mode_o, 2'b00);
        @(negedge PCLK); PRESET_n = 1'b1;
        @(posedge PCLK); #1;

        // Reset register values
        apb_rd(3'd0, rdat, perr); check("cr1_rst", rdat, 8'h04); check("cr1_rd_err", perr, 0);
        apb_rd(3'd2, rdat, perr); check("br_rst", rdat, 8'h00);
        apb_rd(3'd3, rdat, perr); check("sr_rst", rdat, 8'h28);

        // Fill TX: four accepted, fifth errors
        for (int i = 0; i < 4; i++) begin
            apb_wr(3'd5, 8'h11 * (i + 1), perr);
            check("dr_wr_ok", perr, 0);
        end
        apb_wr(3'd5, 8'h55, perr); check("dr_wr_full_err", perr, 1);
        apb_rd(3'd3, rdat, perr); check("sr_txfull", rdat, 8'h00);
        check("txvalid_spe0", tx_valid_o, 0);

        // Enable, then push+pop at full across pointer wrap
        apb_wr(3'd0, 8'h40, perr);
        check("txvalid_spe1", tx_valid_o, 1);
        check("txdata_head", tx_data_o, 8'h11);
        xfer(1'b1, 3'd5, 8'h55, 1'b1, rdat, perr);
        check("dr_wr_pop_full", perr, 0);
        apb_rd(3'd3, rdat, perr); check("sr_still_full", rdat, 8'h00);
        exp_tx[0] = 8'h22; exp_tx[1] = 8'h33; exp_tx[2] = 8'h44; exp_tx[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            check("tx_order", tx_data_o, exp_tx[i]);
            tx_pulse();
        end
        check("txvalid_empty", tx_valid_o, 0);
        apb_rd(3'd3, rdat, perr); check("sr_tx_drained", rdat, 8'h28);

        // Mode FSM RUN -> WAIT -> STOP
        check("mode_run", spi_mode_o, 2'b00);
        apb_wr(3'd0, 8'h00, perr);
        cycles(1);
        check("mode_wait", spi_mode_o, 2'b01);
        apb_wr(3'd1, 8'h02, perr);
        cycles(1);
        check("mode_stop", spi_mode_o, 2'b10);
        apb_wr(3'd5, 8'h66, perr);
        apb_wr(3'd0, 8'h40, perr);
        cycles(1);
        check("mode_stop_spe", spi_mode_o, 2'b10);
        check("txvalid_stop", tx_valid_o, 0);
        apb_wr(3'd1, 8'h00, perr);
        cycles(2);
        check("mode_back_run", spi_mode_o, 2'b00);
        check("txvalid_run", tx_valid_o, 1);
        check("txdata_66", tx_data_o, 8'h66);
        tx_pulse();

        // Write masks, tip_i protection, illegal accesses
        apb_wr(3'd2, 8'hFF, perr); apb_rd(3'd2, rdat, perr); check("br_mask", rdat, 8'h77);
        check("spr_o", spr_o, 3'd7);
        apb_wr(3'd1, 8'hE4, perr); apb_rd(3'd1, rdat, perr); check("cr2_mask", rdat, 8'h00);
        tip_i = 1'b1;
        apb_wr(3'd2, 8'h11, perr); check("br_tip_err", perr, 1);
        tip_i = 1'b0;
        apb_rd(3'd2, rdat, perr); check("br_tip_keep", rdat, 8'h77);
        apb_wr(3'd3, 8'hFF, perr); check("sr_wr_err", perr, 1);
        apb_rd(3'd4, rdat, perr); check("unmapped_err", perr, 1); check("unmapped_data", rdat, 8'h00);

        // RX overflow
        for (int i = 0; i < 5; i++) rx_push(8'hA1 + 8'(i));
        apb_rd(3'd3, rdat, perr); check("sr_rxfull_ovr", rdat, 8'hEC);
        for (int i = 0; i < 4; i++) begin
            apb_rd(3'd5, rdat, perr);
            check("rx_data", rdat, 8'hA1 + 8'(i));
            check("rx_rd_err", perr, 0);
        end
        apb_rd(3'd5, rdat, perr); check("rx_empty_err", perr, 1);
        apb_rd(3'd3, rdat, perr); check("sr_rx_drained", rdat, 8'h68);
        apb_wr(3'd0, 8'h40, perr);
        apb_rd(3'd3, rdat, perr); check("sr_rxovr_clr", rdat, 8'h28);

        // Mode fault and interrupt
        apb_wr(3'd1, 8'h10, perr);
        apb_wr(3'd0, 8'hD0, perr);
        ss_i = 1'b0;
        @(posedge PCLK); #1;
        check("irq_not_yet", irq_o, 0);
        @(posedge PCLK); #1;
`ifdef SPI_IRQ_EN
        check("irq_modf", irq_o, 1);
`else
        check("irq_tied0", irq_o, 0);
`endif
        apb_rd(3'd3, rdat, perr); check("sr_modf", rdat, 8'h38);
`ifdef SPI_IRQ_EN
        apb_rd(3'd0, rdat, perr); check("cr1_full", rdat, 8'hD0);
`else
        apb_rd(3'd0, rdat, perr); check("cr1_masked", rdat, 8'h50);
`endif
        ss_i = 1'b1;
        apb_wr(3'd0, 8'h40, perr);
        apb_rd(3'd3, rdat, perr); check("sr_modf_clr", rdat, 8'h28);
        cycles(2);
        check("irq_clr", irq_o, 0);

        // Asynchronous reset discards FIFO contents
        apb_wr(3'd5, 8'h77, perr);
        rx_push(8'hB1);
        check("txvalid_pre_rst", tx_valid_o, 1);
        #2 PRESET_n = 1'b0;
        #1;
        check("async_txvalid", tx_valid_o, 0);
        check("async_mode", spi_mode_o, 2'b00);
        cycles(2);
        @(negedge PCLK); PRESET_n = 1'b1;
        @(posedge PCLK); #1;
        apb_rd(3'd3, rdat, perr); check("sr_after_rst", rdat, 8'h28);
        apb_rd(3'd0, rdat, perr); check("cr1_after_rst", rdat, 8'h04);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_apb_fifo_ctrl.md
SPI_APB_FIFO_CTRL -- requirements
Module: spi_apb_fifo_ctrl

Interface
REQ-001 SHALL take parameter DATA_W, default 8: width of the data register and of the FIFO words (8, 16 or 32).
REQ-002 SHALL take parameter FIFO_DEPTH, default 4: entries per TX/RX FIFO (power of 2, 2..16).
REQ-003 SHALL have port PCLK, input, 1: clock. All logic is on the rising edge.
REQ-004 SHALL have port PRESET_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have APB ports PSEL, PENABLE, PWRITE (input, 1 each) and PADDR (input, 3).
REQ-006 SHALL have APB port PWDATA (input, DATA_W).
REQ-007 SHALL have APB ports PRDATA (output, DATA_W), PREADY (output, 1) and PSLVERR (output, 1).
REQ-008 SHALL have TX ports tx_data_o (output, DATA_W), tx_valid_o (output, 1) and tx_ready_i (input, 1): the shift core pops the TX FIFO.
REQ-009 SHALL have RX ports rx_data_i (input, DATA_W) and rx_valid_i (input, 1): the shift core pushes a received word.
REQ-010 SHALL have status inputs tip_i (input, 1, transfer in progress) and ss_i (input, 1, slave select, active-low).
REQ-011 SHALL have configuration outputs mstr_o, cpol_o, cpha_o, lsbfe_o (output, 1 each), sppr_o and spr_o (output, 3 each), spi_mode_o (output, 2) and irq_o (output, 1).

Function
REQ-012 SHALL use this register map: 0 CR1, 1 CR2, 2 BR, 3 SR (read-only), 5 DR. Other addresses read 0.
REQ-013 CR1 SHALL hold bit 7 spie, 6 spe, 5 sptie, 4 mstr, 3 cpol, 2 cpha, 1 ssoe, 0 lsbfe.
REQ-014 CR2 SHALL use write mask 0x1B (bit 4 modfen, bit 3 bidiroe, bit 1 spiswai, bit 0 spc0). BR SHALL use write mask 0x77.
REQ-015 APB SHALL have zero wait states: PREADY=1 whenever PSEL&PENABLE; registers update on that access-phase edge only.
REQ-016 PSLVERR SHALL equal 1 in the access phase for any of:
- a write to SR;
- an unmapped address;
- a DR write while TX is full;
- a DR read while RX is empty;
- any write to CR1, CR2 or BR while tip_i=1.
An errored access SHALL change no state.
REQ-017 A DR write SHALL push PWDATA into the TX FIFO. A DR read SHALL return the RX FIFO head combinationally and pop it on the access edge.
REQ-018 tx_valid_o SHALL equal (TX not empty) & spe & (spi_mode_o != STOP). A word SHALL pop when tx_valid_o & tx_ready_i. tx_data_o SHALL equal the TX head.
REQ-019 rx_valid_i with RX full SHALL drop the word and set the sticky flag rxovr.
REQ-020 A push and a pop in the same cycle on either FIFO SHALL both take effect with the count unchanged, including at full and at empty. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 SR SHALL read as follows:
- bit 7 spif = RX not empty;
- bit 6 rxovr;
- bit 5 sptef = TX not full;
- bit 4 modf;
- bit 3 txempty;
- bit 2 rxfull;
- bits [1:0] = 0.
REQ-022 modf SHALL set when !ss_i & mstr & modfen & !ssoe, and stay set (sticky). An SR read followed by a CR1 write SHALL clear modf and rxovr.
REQ-023 The mode FSM (RUN=00, WAIT=01, STOP=10) SHALL drive spi_mode_o directly and transition as follows:
- RUN->WAIT when !spe;
- WAIT->RUN when spe;
- WAIT->STOP when spiswai;
- STOP->WAIT when !spiswai.
Encoding 11 SHALL return to RUN.
REQ-024 The rx_valid_i push SHALL be honoured in any mode (the core gates it).

Reset
REQ-025 While PRESET_n=0 the block SHALL hold:
- CR1=0x04, CR2=0, BR=0, FIFOs empty, flags 0, FSM=RUN;
- tx_valid_o=0, irq_o=0, PSLVERR=0, spi_mode_o=00.
REQ-026 Reset asserted mid-transfer SHALL discard FIFO contents immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro SPI_IRQ_EN, when defined, SHALL set irq_o = spie&(spif|modf|rxovr) | sptie&sptef, registered (one-cycle latency).
REQ-028 Without SPI_IRQ_EN, irq_o SHALL be tied 0 and CR1 bits 7 and 5 SHALL read 0 and ignore writes.

Structure
REQ-029 Package spi_apb_pkg SHALL hold the register address constants, the CR2/BR write masks, the SR bit indices and the mode encodings.
REQ-030 One sub-module, spi_sync_fifo (parameters DATA_W, FIFO_DEPTH; count-based full/empty), SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-031 The bench SHALL cover: reset, then read CR1, BR, SR -> 0x04, 0x00, 0x28.
REQ-032 The bench SHALL cover: 5 DR writes with FIFO_DEPTH=4 and tx_ready_i=0 -> 4 accepted, 5th PSLVERR=1, SR bit 5=0.
REQ-033 The bench SHALL cover: 5 rx_valid_i pushes (0xA1..0xA5) -> reads return 0xA1..0xA4, rxovr=1, and a 5th DR read gives PSLVERR.
REQ-034 The bench SHALL cover: simultaneous DR write and tx pop at full -> count stays 4, and order is preserved across pointer wrap.
REQ-035 The bench SHALL cover: CR1 spe 1->0, then CR2 spiswai=1 -> spi_mode_o goes 00->01->10, and tx_valid_o=0 in STOP.
REQ-036 The bench SHALL cover: SPI_IRQ_EN defined, CR1=0xD0, ss_i=0, modfen=1 -> modf=1 and irq_o=1 one cycle later; SR read then CR1 write clears modf.
